// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: zero-fills x1..x(NREGS-1) after reset,
// then arbitrates round-robin between two writeback requesters (A = ALU, B = load).
module regfile_wb_ctrl #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int NREGS = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_waddr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_waddr,
    input  logic [DW-1:0] b_wdata,
    output logic          we3,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wd3,
    output logic          init_done,
    output logic          state_dbg
);

    // Handshake: a request is transferred on a rising edge where valid && ready;
    // requesters hold valid/waddr/wdata stable until then. Ready never depends on
    // anything but valids, the pointer, state and reset.
    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ptr_q, ptr_d;          // 0 favours A, 1 favours B
    logic          we3_q, we3_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wd3_q, wd3_d;
    logic          init_done_q, init_done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            cnt_q       <= AW'(1);
            ptr_q       <= 1'b0;
            we3_q       <= 1'b0;
            waddr_q     <= '0;
            wd3_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            we3_q       <= we3_d;
            waddr_q     <= waddr_d;
            wd3_q       <= wd3_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_INIT && cnt_q == LAST_REG) begin
            state_d = S_RUN;
        end
    end

    always_comb begin
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        we3_d       = 1'b0;
        waddr_d     = waddr_q;
        wd3_d       = wd3_q;
        init_done_d = (state_q == S_RUN);
        if (state_q == S_INIT) begin
            we3_d   = 1'b1;
            waddr_d = cnt_q;
            wd3_d   = '0;
            cnt_d   = cnt_q + AW'(1);
        end else if (!reset) begin
            a_ready = a_valid && (!b_valid || !ptr_q);
            b_ready = b_valid && (!a_valid || ptr_q);
            // x0 writes are accepted so the requester moves on, but never reach the array.
            if (a_ready) begin
                we3_d   = (a_waddr != '0);
                waddr_d = a_waddr;
                wd3_d   = a_wdata;
                ptr_d   = 1'b1;
            end else if (b_ready) begin
                we3_d   = (b_waddr != '0);
                waddr_d = b_waddr;
                wd3_d   = b_wdata;
                ptr_d   = 1'b0;
            end
        end
    end

    assign we3       = we3_q;
    assign waddr     = waddr_q;
    assign wd3       = wd3_q;
    assign init_done = init_done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: expected writes are queued as they are handed over
// and compared as they appear on the register-file port.
module tb_regfile_wb_ctrl;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREGS = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_waddr, b_waddr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          we3;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wd3;
    logic          init_done;
    logic          state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    logic [AW+DW-1:0] exp_q[$];

    regfile_wb_ctrl #(.DW(DW), .AW(AW), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
        .we3(we3), .waddr(waddr), .wd3(wd3), .init_done(init_done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every registered write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (we3 === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'(we3), 64'(0));
            end else begin
                check("wr_data", 64'({waddr, wd3}), 64'(exp_q.pop_front()));
            end
        end
    end

    // Main-thread sampling point: after the scoreboard, well clear of posedge.
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic step(input logic exp_a, input logic exp_b);
        logic exp_we;
        #1;
        check("a_ready", 64'(a_ready), 64'(exp_a));
        check("b_ready", 64'(b_ready), 64'(exp_b));
        exp_we = 1'b0;
        if (exp_a) begin
            exp_we = (a_waddr != '0);
            if (exp_we) exp_q.push_back({a_waddr, a_wdata});
        end else if (exp_b) begin
            exp_we = (b_waddr != '0);
            if (exp_we) exp_q.push_back({b_waddr, b_wdata});
        end
        tick();
        check("we3_latency", 64'(we3), 64'(exp_we));
    endtask

    task automatic fill(input int n);
        for (int k = 1; k <= n; k++) exp_q.push_back({AW'(k), DW'(0)});
        for (int k = 1; k <= n; k++) begin
            tick();
            check("fill_we3", 64'(we3), 64'(1));
            check("fill_waddr", 64'(waddr), 64'(k));
            check("fill_wd3", 64'(wd3), 64'(0));
            check("fill_init_done", 64'(init_done), 64'(0));
            check("fill_a_ready", 64'(a_ready), 64'(0));
            check("fill_b_ready", 64'(b_ready), 64'(0));
            if (k == 25) begin
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
        end
        if (n == NREGS - 1) begin
            tick();
            check("post_fill_we3", 64'(we3), 64'(0));
            check("init_done_rise", 64'(init_done), 64'(1));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        tick();
        check("rst_we3", 64'(we3), 64'(0));
        check("rst_init_done", 64'(init_done), 64'(0));
        check("rst_a_ready", 64'(a_ready), 64'(0));
        check("rst_b_ready", 64'(b_ready), 64'(0));
        reset = 1'b0;
    endtask

    initial begin
        int ai;
        int bi;
        logic ga;
        reset = 1'b1;
        a_valid = 1'b1; a_waddr = 5'd2; a_wdata = 32'h1111;
        b_valid = 1'b1; b_waddr = 5'd3; b_wdata = 32'h2222;
        tick();
        tick();
        check("rst_we3", 64'(we3), 64'(0));
        check("rst_waddr", 64'(waddr), 64'(0));
        check("rst_wd3", 64'(wd3), 64'(0));
        check("rst_init_done", 64'(init_done), 64'(0));
        check("rst_a_ready", 64'(a_ready), 64'(0));
        check("rst_b_ready", 64'(b_ready), 64'(0));

        reset = 1'b0;
        fill(NREGS - 1);

        // A only, then B only, so the pointer favours A for the contention run.
        a_valid = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEADBEEF;
        step(1'b1, 1'b0);
        a_valid = 1'b0;
        b_valid = 1'b1; b_waddr = 5'd7; b_wdata = 32'h77;
        step(1'b0, 1'b1);
        b_valid = 1'b0;

        ai = 1;
        bi = 32'h10;
        for (int k = 0; k < 4; k++) begin
            a_valid = 1'b1; a_waddr = 5'd3; a_wdata = DW'(ai);
            b_valid = 1'b1; b_waddr = 5'd4; b_wdata = DW'(bi);
            ga = (k % 2 == 0);
            step(ga, !ga);
            if (ga) ai++; else bi++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        step(1'b0, 1'b0);

        b_valid = 1'b1; b_waddr = 5'd0; b_wdata = 32'hFFFFFFFF;
        step(1'b0, 1'b1);
        a_valid = 1'b1; a_waddr = 5'd6; a_wdata = 32'hA5A5A5A5;
        b_valid = 1'b1; b_waddr = 5'd8; b_wdata = DW'($urandom_range(0, 1000));
        step(1'b1, 1'b0);
        a_valid = 1'b0;
        step(1'b0, 1'b1);
        b_valid = 1'b0;

        // Reset in the middle of the fill, when the counter holds 10.
        do_reset();
        fill(9);
        do_reset();
        fill(NREGS - 1);

        // Reset in RUN with a request pending: nothing may be written.
        a_valid = 1'b1; a_waddr = 5'd9; a_wdata = 32'h55;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("rst_run_a_ready", 64'(a_ready), 64'(0));
        tick();
        check("rst_run_we3", 64'(we3), 64'(0));
        reset = 1'b0;
        a_valid = 1'b0;
        fill(NREGS - 1);

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
